// File: rtl/cache_controller_burst_if.sv
// Control bus between the burst cache controller, the CPU port, the cache datapath and main memory.
interface cache_controller_burst_if #(
    parameter int unsigned OFF_W = 2,
    parameter int unsigned CNT_W = 16
);
    logic             MemRead;
    logic             MemWrite;
    logic             HMbar;
    logic             MMDataReady;
    logic             MMWriteDone;
    logic             MMRead;
    logic             MMWrite;
    logic [OFF_W-1:0] MMWordIdx;
    logic             CacheWrite;
    logic [OFF_W-1:0] CacheWordIdx;
    logic             CacheValidSet;
    logic             DataSelect;
    logic             DataReady;
    logic [CNT_W-1:0] HitCount;
    logic [CNT_W-1:0] MissCount;

    // Controller side: consumes requests and status, drives control strobes.
    modport master (
        input  MemRead, MemWrite, HMbar, MMDataReady, MMWriteDone,
        output MMRead, MMWrite, MMWordIdx, CacheWrite, CacheWordIdx,
        output CacheValidSet, DataSelect, DataReady, HitCount, MissCount
    );

    // Environment side: CPU, datapath and main memory.
    modport slave (
        output MemRead, MemWrite, HMbar, MMDataReady, MMWriteDone,
        input  MMRead, MMWrite, MMWordIdx, CacheWrite, CacheWordIdx,
        input  CacheValidSet, DataSelect, DataReady, HitCount, MissCount
    );
endinterface

// File: rtl/cache_controller_burst.sv
// Direct-mapped cache controller: one-cycle read hits, burst refill on read miss,
// write-through without allocate, saturating read hit/miss counters.
module cache_controller_burst #(
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned OFF_W       = $clog2(BLOCK_WORDS),
    parameter int unsigned CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    cache_controller_burst_if.master bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REFILL   = 2'd1,
        RESPOND  = 2'd2,
        WRITE_MM = 2'd3
    } state_t;

    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state;
    state_t           state_next;
    logic [OFF_W-1:0] beat;
    logic [OFF_W-1:0] beat_next;
    logic             hit_inc;
    logic             miss_inc;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Beat counter and saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat     <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            beat <= beat_next;
            if (hit_inc && (hit_cnt != CNT_MAX)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
            if (miss_inc && (miss_cnt != CNT_MAX)) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state, beat and counter-increment decode; a read wins over a simultaneous write.
    always_comb begin
        state_next = state;
        beat_next  = beat;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.MemRead) begin
                    if (bus.HMbar) begin
                        hit_inc = 1'b1;
                    end else begin
                        state_next = REFILL;
                        beat_next  = '0;
                        miss_inc   = 1'b1;
                    end
                end else if (bus.MemWrite) begin
                    state_next = WRITE_MM;
                end
            end
            REFILL: begin
                if (bus.MMDataReady) begin
                    beat_next = beat + OFF_W'(1);
                    if (beat == LAST_BEAT) begin
                        state_next = RESPOND;
                    end
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            WRITE_MM: begin
                if (bus.MMWriteDone) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode; everything is held low while reset is asserted.
    always_comb begin
        bus.MMRead        = 1'b0;
        bus.MMWrite       = 1'b0;
        bus.MMWordIdx     = '0;
        bus.CacheWrite    = 1'b0;
        bus.CacheWordIdx  = '0;
        bus.CacheValidSet = 1'b0;
        bus.DataSelect    = 1'b0;
        bus.DataReady     = 1'b0;
        bus.HitCount      = '0;
        bus.MissCount     = '0;
        if (!rst) begin
            bus.HitCount  = hit_cnt;
            bus.MissCount = miss_cnt;
            unique case (state)
                IDLE: begin
                    if (bus.MemRead) begin
                        bus.DataReady = bus.HMbar;
                    end else if (bus.MemWrite) begin
                        // CPU write data; the datapath supplies the real word offset.
                        bus.MMWrite    = 1'b1;
                        bus.CacheWrite = bus.HMbar;
                    end
                end
                REFILL: begin
                    bus.MMRead    = 1'b1;
                    bus.MMWordIdx = beat;
                    if (bus.MMDataReady) begin
                        bus.CacheWrite    = 1'b1;
                        bus.DataSelect    = 1'b1;
                        bus.CacheWordIdx  = beat;
                        bus.CacheValidSet = (beat == LAST_BEAT);
                    end
                end
                RESPOND: begin
                    bus.DataReady = 1'b1;
                end
                WRITE_MM: begin
                    bus.MMWrite   = 1'b1;
                    bus.DataReady = bus.MMWriteDone;
                end
                default: begin
                    bus.DataReady = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller_burst.sv
// Bench for cache_controller_burst: vector table, corner sequences and random traffic
// against a transaction-level reference model.
module tb_cache_controller_burst;

    localparam int unsigned BW    = 4;
    localparam int unsigned OFF_W = 2;

    // {MMRead, MMWrite, MMWordIdx, CacheWrite, CacheWordIdx, CacheValidSet,
    //  DataSelect, DataReady, HitCount16, MissCount16, HitCount2, MissCount2}
    typedef logic [45:0] vec_t;

    typedef struct {
        bit          rst, mr, mw, hm, mdr, mwd;
        logic [41:0] exp;
    } tab_t;

    logic clk;
    logic rst;
    bit   r_mr, r_mw, r_hm, r_mdr, r_mwd;

    cache_controller_burst_if #(.OFF_W(OFF_W), .CNT_W(16)) bus   ();
    cache_controller_burst_if #(.OFF_W(OFF_W), .CNT_W(2))  bus_s ();

    cache_controller_burst #(.BLOCK_WORDS(BW), .OFF_W(OFF_W), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cache_controller_burst #(.BLOCK_WORDS(BW), .OFF_W(OFF_W), .CNT_W(2)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    assign bus.MemRead       = r_mr;
    assign bus.MemWrite      = r_mw;
    assign bus.HMbar         = r_hm;
    assign bus.MMDataReady   = r_mdr;
    assign bus.MMWriteDone   = r_mwd;
    assign bus_s.MemRead     = r_mr;
    assign bus_s.MemWrite    = r_mw;
    assign bus_s.HMbar       = r_hm;
    assign bus_s.MMDataReady = r_mdr;
    assign bus_s.MMWriteDone = r_mwd;

    vec_t dv;
    assign dv = {bus.MMRead, bus.MMWrite, bus.MMWordIdx, bus.CacheWrite, bus.CacheWordIdx,
                 bus.CacheValidSet, bus.DataSelect, bus.DataReady, bus.HitCount, bus.MissCount,
                 bus_s.HitCount, bus_s.MissCount};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t got;

    // Reference model: outstanding transaction kind plus words delivered so far.
    bit m_refill, m_respond, m_write;
    int m_words, m_hits, m_misses;

    function automatic int sat(input int v, input int cap);
        return (v > cap) ? cap : v;
    endfunction

    task automatic model_cycle(output vec_t e);
        bit mmr, mmw, cw, cvs, ds, dr;
        int midx, cidx, h, m;
        mmr = 0; mmw = 0; cw = 0; cvs = 0; ds = 0; dr = 0; midx = 0; cidx = 0;
        h = m_hits; m = m_misses;
        if (rst) begin
            m_refill = 0; m_respond = 0; m_write = 0;
            m_words = 0; m_hits = 0; m_misses = 0;
            e = '0;
            return;
        end
        if (m_refill) begin
            mmr = 1; midx = m_words;
            if (r_mdr) begin
                cw = 1; ds = 1; cidx = m_words;
                cvs = (m_words == BW - 1);
                m_words++;
                if (m_words == BW) begin
                    m_refill = 0; m_respond = 1; m_words = 0;
                end
            end
        end else if (m_respond) begin
            dr = 1; m_respond = 0;
        end else if (m_write) begin
            mmw = 1;
            if (r_mwd) begin
                dr = 1; m_write = 0;
            end
        end else if (r_mr) begin
            if (r_hm) begin
                dr = 1; m_hits++;
            end else begin
                m_misses++; m_refill = 1; m_words = 0;
            end
        end else if (r_mw) begin
            mmw = 1; cw = r_hm; m_write = 1;
        end
        e = {mmr, mmw, 2'(midx), cw, 2'(cidx), cvs, ds, dr,
             16'(sat(h, 65535)), 16'(sat(m, 65535)), 2'(sat(h, 3)), 2'(sat(m, 3))};
    endtask

    // One clock: inputs already applied at edge+1, sample at edge+4, advance.
    task automatic step(input string tag, input bit use_tab, input logic [41:0] te);
        vec_t e;
        #3;
        model_cycle(e);
        got = dv;
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, e);
        end
        if (use_tab) begin
            n_vec++;
            if (got[45:4] !== te) begin
                n_bad++;
                $display("FAIL %s_table t=%0t got=%h exp=%h", tag, $time, got[45:4], te);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input int g, input int e);
        n_vec++;
        if (g != e) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, g, e);
        end
    endtask

    task automatic set_in(input bit rs, mr, mw, hm, mdr, mwd);
        rst = rs; r_mr = mr; r_mw = mw; r_hm = hm; r_mdr = mdr; r_mwd = mwd;
    endtask

    function automatic tab_t r(input bit rs, mr, mw, hm, mdr, mwd,
                               input bit mmr, mmw, input int midx, input bit cw,
                               input int cidx, input bit cvs, ds, dr, input int hit, miss);
        tab_t t;
        t.rst = rs; t.mr = mr; t.mw = mw; t.hm = hm; t.mdr = mdr; t.mwd = mwd;
        t.exp = {mmr, mmw, 2'(midx), cw, 2'(cidx), cvs, ds, dr, 16'(hit), 16'(miss)};
        return t;
    endfunction

    tab_t tab [0:25];

    initial begin
        int cw_n, last_beat, dr_k;

        //          rs mr mw hm md wd | mmr mmw midx cw cidx cvs ds dr hit miss
        tab[0]  = r(1, 1, 0, 1, 0, 0,   0,  0,  0,   0, 0,   0,  0, 0, 0, 0);
        tab[1]  = r(0, 1, 0, 1, 0, 0,   0,  0,  0,   0, 0,   0,  0, 1, 0, 0);
        tab[2]  = r(0, 1, 0, 1, 0, 0,   0,  0,  0,   0, 0,   0,  0, 1, 1, 0);
        tab[3]  = r(0, 1, 0, 1, 0, 0,   0,  0,  0,   0, 0,   0,  0, 1, 2, 0);
        tab[4]  = r(0, 0, 0, 0, 0, 0,   0,  0,  0,   0, 0,   0,  0, 0, 3, 0);
        tab[5]  = r(0, 1, 0, 0, 0, 0,   0,  0,  0,   0, 0,   0,  0, 0, 3, 0);
        tab[6]  = r(0, 1, 0, 0, 1, 0,   1,  0,  0,   1, 0,   0,  1, 0, 3, 1);
        tab[7]  = r(0, 1, 0, 0, 1, 0,   1,  0,  1,   1, 1,   0,  1, 0, 3, 1);
        tab[8]  = r(0, 1, 0, 0, 1, 0,   1,  0,  2,   1, 2,   0,  1, 0, 3, 1);
        tab[9]  = r(0, 1, 0, 0, 1, 0,   1,  0,  3,   1, 3,   1,  1, 0, 3, 1);
        tab[10] = r(0, 1, 0, 0, 1, 0,   0,  0,  0,   0, 0,   0,  0, 1, 3, 1);
        tab[11] = r(0, 0, 1, 1, 0, 0,   0,  1,  0,   1, 0,   0,  0, 0, 3, 1);
        tab[12] = r(0, 0, 1, 1, 0, 0,   0,  1,  0,   0, 0,   0,  0, 0, 3, 1);
        tab[13] = r(0, 0, 1, 1, 0, 0,   0,  1,  0,   0, 0,   0,  0, 0, 3, 1);
        tab[14] = r(0, 0, 1, 1, 0, 0,   0,  1,  0,   0, 0,   0,  0, 0, 3, 1);
        tab[15] = r(0, 0, 1, 1, 0, 0,   0,  1,  0,   0, 0,   0,  0, 0, 3, 1);
        tab[16] = r(0, 0, 1, 1, 0, 1,   0,  1,  0,   0, 0,   0,  0, 1, 3, 1);
        tab[17] = r(0, 0, 1, 0, 0, 0,   0,  1,  0,   0, 0,   0,  0, 0, 3, 1);
        tab[18] = r(0, 0, 1, 0, 1, 1,   0,  1,  0,   0, 0,   0,  0, 1, 3, 1);
        tab[19] = r(0, 1, 1, 0, 0, 0,   0,  0,  0,   0, 0,   0,  0, 0, 3, 1);
        tab[20] = r(0, 1, 1, 0, 0, 0,   1,  0,  0,   0, 0,   0,  0, 0, 3, 2);
        tab[21] = r(0, 1, 1, 0, 1, 0,   1,  0,  0,   1, 0,   0,  1, 0, 3, 2);
        tab[22] = r(1, 1, 1, 0, 1, 0,   0,  0,  0,   0, 0,   0,  0, 0, 0, 0);
        tab[23] = r(0, 0, 0, 0, 0, 0,   0,  0,  0,   0, 0,   0,  0, 0, 0, 0);
        tab[24] = r(0, 1, 0, 0, 0, 0,   0,  0,  0,   0, 0,   0,  0, 0, 0, 0);
        tab[25] = r(0, 1, 0, 0, 0, 0,   1,  0,  0,   0, 0,   0,  0, 0, 0, 1);

        set_in(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Directed vector table.
        for (int i = 0; i < 26; i++) begin
            set_in(tab[i].rst, tab[i].mr, tab[i].mw, tab[i].hm, tab[i].mdr, tab[i].mwd);
            step($sformatf("tab%0d", i), 1'b1, tab[i].exp);
        end

        // Refill with a beat only every third cycle.
        set_in(1, 0, 0, 0, 0, 0);
        step("stall_rst", 1'b0, '0);
        set_in(0, 1, 0, 0, 0, 0);
        step("stall_req", 1'b0, '0);
        cw_n = 0; last_beat = -100; dr_k = -1;
        for (int k = 0; k < 60; k++) begin
            r_mdr = (k % 3 == 2);
            step("stall", 1'b0, '0);
            if (got[41]) begin
                cw_n++;
                last_beat = k;
            end
            if (got[36]) begin
                dr_k = k;
                break;
            end
        end
        set_in(0, 0, 0, 0, 0, 0);
        check_eq("stall_cachewrite_pulses", cw_n, 4);
        check_eq("stall_ready_delay", dr_k - last_beat, 1);

        // Narrow-counter saturation.
        set_in(1, 0, 0, 0, 0, 0);
        step("sat_rst", 1'b0, '0);
        for (int k = 0; k < 5; k++) begin
            set_in(0, 1, 0, 1, 0, 0);
            step("sat_hit", 1'b0, '0);
        end
        set_in(0, 0, 0, 0, 0, 0);
        step("sat_idle", 1'b0, '0);
        check_eq("sat_hit2", int'(got[3:2]), 3);
        check_eq("sat_hit16", int'(got[35:20]), 5);

        // Random traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            set_in($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
            step("rand", 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_controller_burst.md
# cache_controller_burst

Parametrised successor to the single-word read-only cache controller. Sequences CPU reads and writes against a direct-mapped cache and main memory (MM): one-cycle read hits, multi-word block refill on read miss, write-through (no write-allocate) with an MM write handshake, and saturating hit/miss counters. Sits between the CPU memory port, the cache datapath (data/tag/valid arrays, data mux) and the MM interface. It drives control signals only; addresses and data are routed by the datapath.

## Interface
Parameters:
- BLOCK_WORDS, 4: words per cache block (power of two, ≥ 2).
- OFF_W, $clog2(BLOCK_WORDS): word-offset width.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- MemRead  in  1  CPU read request, held until DataReady.
- MemWrite  in  1  CPU write request, held until DataReady.
- HMbar  in  1  tag compare result from datapath (1 = hit).
- MMDataReady  in  1  MM read beat valid (one word per assertion).
- MMWriteDone  in  1  MM write accepted.
- MMRead  out  1  MM read request, held for the whole refill.
- MMWrite  out  1  MM write request (write-through).
- MMWordIdx  out  OFF_W  word offset of the current refill beat.
- CacheWrite  out  1  write strobe for the cache data array.
- CacheWordIdx  out  OFF_W  word offset written when CacheWrite=1.
- CacheValidSet  out  1  set valid bit and load tag for the indexed block.
- DataSelect  out  1  cache write-data mux: 0 = CPU data, 1 = MM data.
- DataReady  out  1  request complete, CPU may proceed.
- HitCount  out  CNT_W  saturating read-hit count.
- MissCount  out  CNT_W  saturating read-miss count.

## Operation
States: IDLE, REFILL, RESPOND, WRITE_MM. Beat counter `beat` (OFF_W bits).
- IDLE:
  - MemRead & HMbar: DataReady=1 in the same cycle (combinational). Stay in IDLE. HitCount += 1.
  - MemRead & !HMbar: go to REFILL, beat←0, MissCount += 1.
  - MemWrite & !MemRead: MMWrite=1. If HMbar=1, also CacheWrite=1, DataSelect=0 and CacheWordIdx=0 in this cycle (the datapath supplies the real offset for CPU writes). Go to WRITE_MM.
  - MemRead & MemWrite together: the read has priority. The write is not accepted.
- REFILL:
  - MMRead=1 and MMWordIdx=beat.
  - On MMDataReady: CacheWrite=1, DataSelect=1, CacheWordIdx=beat, beat←beat+1.
  - On MMDataReady with beat==BLOCK_WORDS-1: also CacheValidSet=1, beat wraps to 0, go to RESPOND.
- RESPOND: DataReady=1, DataSelect=0. Go to IDLE. The hit re-read comes from the now-valid block and is not counted as a hit.
- WRITE_MM: MMWrite=1. On MMWriteDone: DataReady=1 in the same cycle, go to IDLE.
- Counters saturate at 2^CNT_W−1 and never wrap.
- MemRead, MemWrite and HMbar are not sampled outside IDLE.
- MMDataReady is ignored outside REFILL. MMWriteDone is ignored outside WRITE_MM.

## Timing
- Reset:
  - State=IDLE, beat=0, HitCount=0, MissCount=0.
  - While rst=1, all outputs are forced to 0, including combinational DataReady.
- Read hit latency: 0 cycles (DataReady in the request cycle).
- Read miss latency: 1 cycle (IDLE→REFILL), plus the cycles until BLOCK_WORDS MMDataReady beats, plus 1 RESPOND cycle.
  - With back-to-back beats and BLOCK_WORDS=4: DataReady is high in cycle 6, where the request is cycle 1.
- MMRead rises the cycle after the miss is detected. It stays high continuously through the last beat and is low in RESPOND.
- MMDataReady may stall (deassert) for any number of cycles mid-burst. beat holds during a stall.
- Write latency: 1 cycle, plus the wait for MMWriteDone. MMWrite is high from the accept cycle through the MMWriteDone cycle.
- Reset mid-refill: abort immediately. No CacheValidSet, MMRead=0 in the reset cycle, counters cleared.
- Reset mid-write: MMWrite=0 in the reset cycle. No DataReady.
- CacheValidSet is a single-cycle pulse, only on the last refill beat.

## Test plan
- Reset, then MemRead=1 and HMbar=1 held for 3 cycles → DataReady=1 in each of the 3 cycles, HitCount=3, MissCount=0, MMRead never asserted.
- BLOCK_WORDS=4 read miss with MMDataReady high every cycle → MMWordIdx=0,1,2,3 on successive cycles, CacheWrite and DataSelect=1 on each beat, CacheValidSet only with idx 3, DataReady in RESPOND, MissCount=1.
- Read miss with MMDataReady asserted only every third cycle → beat holds during stalls, exactly 4 CacheWrite pulses, DataReady 1 cycle after the 4th beat.
- Write hit followed by a write miss, with MMWriteDone 5 cycles after accept:
  - Write hit → CacheWrite=1 with DataSelect=0 only in the accept cycle, MMWrite high for 6 cycles, DataReady with MMWriteDone.
  - Write miss → no CacheWrite.
- Reset asserted on the 2nd beat of a refill → next cycle IDLE, no CacheValidSet, counters 0. A subsequent miss restarts at MMWordIdx=0.
- CNT_W=2, 5 read hits → HitCount saturates at 3. Also drive MemRead and MemWrite together on a miss → a refill starts and MMWrite stays 0.
